// File: rtl/cam_init_pkg.sv
// Shared state encoding, default timing and pin decode for the OV5640 power-up sequencer.
package cam_init_pkg;

    localparam int T_PWDN_CYC_DEF  = 250000;
    localparam int T_RST_CYC_DEF   = 50000;
    localparam int T_BOOT_CYC_DEF  = 1000000;
    localparam int TIMEOUT_CYC_DEF = 50000000;
    localparam int MAX_RETRY_DEF   = 3;
    localparam int CNT_W_DEF       = 26;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWDN_HOLD = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_BOOT_WAIT = 3'd3,
        ST_CFG_RUN   = 3'd4,
        ST_FAILCHK   = 3'd5,
        ST_DONE      = 3'd6,
        ST_FAIL      = 3'd7
    } state_e;

    typedef struct packed {
        logic cfg_rst;
        logic cam_pwdn;
        logic cam_rst_n;
    } pins_t;

    // The config engine only runs in CFG_RUN; the sensor is powered down outside an active attempt.
    function automatic pins_t state_pins(input state_e s);
        pins_t p;
        case (s)
            ST_IDLE:      p = '{cfg_rst: 1'b1, cam_pwdn: 1'b1, cam_rst_n: 1'b0};
            ST_PWDN_HOLD: p = '{cfg_rst: 1'b1, cam_pwdn: 1'b1, cam_rst_n: 1'b0};
            ST_RST_HOLD:  p = '{cfg_rst: 1'b1, cam_pwdn: 1'b0, cam_rst_n: 1'b0};
            ST_BOOT_WAIT: p = '{cfg_rst: 1'b1, cam_pwdn: 1'b0, cam_rst_n: 1'b1};
            ST_CFG_RUN:   p = '{cfg_rst: 1'b0, cam_pwdn: 1'b0, cam_rst_n: 1'b1};
            ST_FAILCHK:   p = '{cfg_rst: 1'b1, cam_pwdn: 1'b0, cam_rst_n: 1'b1};
            ST_DONE:      p = '{cfg_rst: 1'b1, cam_pwdn: 1'b0, cam_rst_n: 1'b1};
            default:      p = '{cfg_rst: 1'b1, cam_pwdn: 1'b1, cam_rst_n: 1'b0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cam_init_timer.sv
// Dwell timer for the camera sequencer: up-counter with synchronous clear and terminal-count compare.
module cam_init_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == limit);

endmodule

// File: rtl/cam_init_sequencer.sv
// OV5640 power-up / configuration sequencer. Build option: CAM_INIT_RETRY_EN enables
// re-running the full power cycle after a failed configuration attempt (up to MAX_RETRY times).
//
// state      | meaning
// IDLE       | waiting for start, sensor powered down
// PWDN_HOLD  | PWDN asserted, RESETB low
// RST_HOLD   | power applied, RESETB still low
// BOOT_WAIT  | RESETB released, sensor boot time
// CFG_RUN    | i2c_config engine running, timeout armed
// FAILCHK    | decide between retry and final failure
// DONE       | configuration succeeded
// FAIL       | configuration failed, sensor powered down
module cam_init_sequencer
    import cam_init_pkg::*;
#(
    parameter int T_PWDN_CYC  = T_PWDN_CYC_DEF,
    parameter int T_RST_CYC   = T_RST_CYC_DEF,
    parameter int T_BOOT_CYC  = T_BOOT_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cfg_done,
    input  logic       cfg_error,
    output logic       cfg_rst,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       busy,
    output logic       init_done,
    output logic       init_error,
    output logic [1:0] retry_cnt
);

`ifdef CAM_INIT_RETRY_EN
    localparam bit RETRY_ENABLE = 1'b1;
`else
    localparam bit RETRY_ENABLE = 1'b0;
`endif

    localparam logic [CNT_W-1:0] PWDN_LAST    = CNT_W'(T_PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(T_RST_CYC - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST    = CNT_W'(T_BOOT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [1:0]       retry_q, retry_d;
    logic             cfg_rst_q, cam_pwdn_q, cam_rst_n_q;
    logic             busy_q, busy_d;
    logic             init_done_q, init_done_d;
    logic             init_error_q, init_error_d;
    pins_t            pins_d;

    logic             tmr_clr;
    logic [CNT_W-1:0] tmr_limit;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_expired;
    logic             retry_ok;

    cam_init_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .limit   (tmr_limit),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    assign retry_ok = RETRY_ENABLE && (retry_q < RETRY_MAX);

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        tmr_limit = '0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d = ST_PWDN_HOLD;
                    retry_d = 2'd0;
                end
            end
            ST_PWDN_HOLD: begin
                tmr_limit = PWDN_LAST;
                if (tmr_expired) state_d = ST_RST_HOLD;
            end
            ST_RST_HOLD: begin
                tmr_limit = RST_LAST;
                if (tmr_expired) state_d = ST_BOOT_WAIT;
            end
            ST_BOOT_WAIT: begin
                tmr_limit = BOOT_LAST;
                if (tmr_expired) state_d = ST_CFG_RUN;
            end
            ST_CFG_RUN: begin
                tmr_limit = TIMEOUT_LAST;
                // cfg_done may still hold its pre-reset value in the first cycle after release.
                if (cfg_done && (tmr_count != '0)) begin
                    state_d = cfg_error ? ST_FAILCHK : ST_DONE;
                end else if (tmr_expired) begin
                    state_d = ST_FAILCHK;
                end
            end
            ST_FAILCHK: begin
                if (retry_ok) begin
                    state_d = ST_PWDN_HOLD;
                    retry_d = retry_q + 2'd1;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tmr_clr = (state_d != state_q);

    always_comb begin
        pins_d       = state_pins(state_d);
        busy_d       = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FAIL));
        init_done_d  = (state_d == ST_DONE);
        init_error_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            retry_q      <= 2'd0;
            cfg_rst_q    <= 1'b1;
            cam_pwdn_q   <= 1'b1;
            cam_rst_n_q  <= 1'b0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            cfg_rst_q    <= pins_d.cfg_rst;
            cam_pwdn_q   <= pins_d.cam_pwdn;
            cam_rst_n_q  <= pins_d.cam_rst_n;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
            init_error_q <= init_error_d;
        end
    end

    assign cfg_rst    = cfg_rst_q;
    assign cam_pwdn   = cam_pwdn_q;
    assign cam_rst_n  = cam_rst_n_q;
    assign busy       = busy_q;
    assign init_done  = init_done_q;
    assign init_error = init_error_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Randomized bench for cam_init_sequencer: expected pin/status timelines are built per episode and replayed cycle by cycle.
module tb_cam_init_sequencer;

    localparam int TP = 10;
    localparam int TR = 5;
    localparam int TB = 20;
    localparam int TO = 1000;
    localparam int MR = 2;
`ifdef CAM_INIT_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    // exp = {cfg_rst, cam_pwdn, cam_rst_n, busy, init_done, init_error, retry_cnt[1:0]}
    typedef struct packed {
        logic [7:0] exp;
        logic       is_cfg;
        logic       d_done;
        logic       d_err;
        logic       d_start;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst, start, cfg_done, cfg_error;
    logic       cfg_rst, cam_pwdn, cam_rst_n, busy, init_done, init_error;
    logic [1:0] retry_cnt;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_ent = 0;
    ent_t tr[$];
    ent_t term;

    always #5 clk = ~clk;

    cam_init_sequencer #(
        .T_PWDN_CYC  (TP),
        .T_RST_CYC   (TR),
        .T_BOOT_CYC  (TB),
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (MR),
        .CNT_W       (26)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error),
        .cfg_rst    (cfg_rst),
        .cam_pwdn   (cam_pwdn),
        .cam_rst_n  (cam_rst_n),
        .busy       (busy),
        .init_done  (init_done),
        .init_error (init_error),
        .retry_cnt  (retry_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, obs, expv);
        end
    endtask

    function automatic ent_t mk(input logic [2:0] pins, input logic b, input logic d,
                                input logic er, input logic [1:0] r);
        ent_t e;
        e.exp     = {pins, b, d, er, r};
        e.is_cfg  = 1'b0;
        e.d_done  = 1'b0;
        e.d_err   = 1'b0;
        e.d_start = 1'b0;
        return e;
    endfunction

    function automatic logic [7:0] dut_vec();
        return {cfg_rst, cam_pwdn, cam_rst_n, busy, init_done, init_error, retry_cnt};
    endfunction

    task automatic push_hold(input int n, input bit do_start);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e = term;
            e.d_start = do_start && (i == n - 1);
            tr.push_back(e);
        end
    endtask

    // kind: 0 ok, 1 cfg_error, 2 timeout, 3 done on the timeout cycle, -1 random
    task automatic gen_episode(input int kind_f);
        logic [1:0] r = 2'd0;
        bit         fin = 1'b0;
        int         kind, ridx, len;
        logic       errbit;
        ent_t       e;
        while (!fin) begin
            for (int i = 0; i < TP; i++) tr.push_back(mk(3'b110, 1'b1, 1'b0, 1'b0, r));
            for (int i = 0; i < TR; i++) tr.push_back(mk(3'b100, 1'b1, 1'b0, 1'b0, r));
            for (int i = 0; i < TB; i++) tr.push_back(mk(3'b101, 1'b1, 1'b0, 1'b0, r));
            if (kind_f >= 0) begin
                kind = kind_f;
            end else begin
                kind = $urandom_range(0, 9);
                kind = (kind < 5) ? 0 : (kind < 8) ? 1 : (kind == 8) ? 2 : 3;
            end
            case (kind)
                0:       begin ridx = (kind_f == 0) ? 1 : $urandom_range(1, 25); errbit = 1'b0; end
                1:       begin ridx = $urandom_range(1, 25); errbit = 1'b1; end
                2:       begin ridx = -1; errbit = 1'b0; end
                default: begin ridx = TO - 1; errbit = 1'(($urandom_range(0, 1))); end
            endcase
            len = (ridx < 0) ? TO : ridx + 1;
            for (int i = 0; i < len; i++) begin
                e = mk(3'b001, 1'b1, 1'b0, 1'b0, r);
                e.is_cfg = 1'b1;
                if (i == 0) begin
                    e.d_done = (kind_f == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
                    e.d_err  = 1'(($urandom_range(0, 1)));
                end
                if (i == ridx) begin
                    e.d_done = 1'b1;
                    e.d_err  = errbit;
                end
                tr.push_back(e);
            end
            if (ridx >= 0 && !errbit) begin
                term = mk(3'b101, 1'b0, 1'b1, 1'b0, r);
                fin  = 1'b1;
            end else begin
                tr.push_back(mk(3'b101, 1'b1, 1'b0, 1'b0, r));
                if (RETRY_EN && int'(r) < MR) begin
                    r = r + 2'd1;
                end else begin
                    term = mk(3'b110, 1'b0, 1'b0, 1'b1, r);
                    fin  = 1'b1;
                end
            end
        end
    endtask

    task automatic run_entry();
        ent_t e;
        e = tr.pop_front();
        chk($sformatf("seq%0d", n_ent), dut_vec(), e.exp);
        chk($sformatf("excl%0d", n_ent), {7'd0, init_done & init_error}, 8'd0);
        n_ent++;
        rst   = 1'b0;
        start = e.d_start | (e.exp[4] & ($urandom_range(0, 7) == 0));
        if (e.is_cfg) begin
            cfg_done  = e.d_done;
            cfg_error = e.d_done ? e.d_err : 1'(($urandom_range(0, 1)));
        end else begin
            cfg_done  = 1'(($urandom_range(0, 1)));
            cfg_error = 1'(($urandom_range(0, 1)));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cut;
        int base;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_done  = 1'b0;
        cfg_error = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", dut_vec(), 8'b110_0_0_0_00);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        term = mk(3'b110, 1'b0, 1'b0, 1'b0, 2'd0);
        push_hold($urandom_range(1, 4), 1'b1);
        for (int ep = 0; ep < 10; ep++) begin
            gen_episode((ep < 4) ? ep : -1);
            push_hold($urandom_range(1, 4), ep < 9);
        end
        while (tr.size() > 0) run_entry();

        // reset in the middle of BOOT_WAIT, with start and cfg_done also asserted
        push_hold(1, 1'b1);
        base = tr.size();
        gen_episode(0);
        cut = base + TP + TR + $urandom_range(0, TB - 1);
        for (int i = 0; i < cut; i++) run_entry();
        rst       = 1'b1;
        start     = 1'b1;
        cfg_done  = 1'b1;
        cfg_error = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid", dut_vec(), 8'b110_0_0_0_00);
        tr.delete();
        rst      = 1'b0;
        start    = 1'b0;
        cfg_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_rst", dut_vec(), 8'b110_0_0_0_00);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("restart", dut_vec(), 8'b110_1_0_0_00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
